cap_stream: RTL and testbench

CAP_STREAM -- requirements
Module: cap_stream

---
 rtl/cap_stream_if.sv | 21 ++
 rtl/cap_stream.sv | 121 ++++++++++++
 tb/tb_cap_stream.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cap_stream_if.sv
// rtl/cap_stream_if.sv - lane-packed input/output stream handshake bundle for cap_stream
interface cap_stream_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0] flow;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] result;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output flow, in_valid, out_ready,
        input  in_ready, result, out_valid
    );

    modport slave (
        input  flow, in_valid, out_ready,
        output in_ready, result, out_valid
    );
endinterface

// File: rtl/cap_stream.sv
// rtl/cap_stream.sv - two-stage per-lane capture/transform stream with lane-reversed output
module cap_stream #(
    parameter int SIZE  = 3,
    parameter int NUM   = 4,
    parameter int SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [1:0]           mode,
    input  logic [2**SIZE-1:0]   omega,
    input  logic [2**SIZE-1:0]   epsilon,
    input  logic                 clear,
    input  logic                 enable,
    output logic [15:0]          count,
    output logic                 ready,
    cap_stream_if.slave          bus
);
    localparam int W = 2 ** SIZE;

    logic             s1_valid_q;
    logic [W-1:0]     s1_lane_q [NUM];
    logic [1:0]       s1_mode_q;
    logic [W-1:0]     s1_omega_q;
    logic [W-1:0]     s1_eps_q;

    logic             s2_valid_q;
    logic [NUM*W-1:0] result_q;
    logic [NUM*W-1:0] result_d;

    logic [W-1:0]     acc_q [NUM];
    logic [W-1:0]     acc_d [NUM];
    logic [15:0]      count_q;

    logic [W:0]        sum   [NUM];
    logic signed [W:0] diff  [NUM];
    logic [W-1:0]      y     [NUM];

    logic adv;
    logic accept;
    logic xfer;
    logic handshake;

    assign adv       = enable && (!s2_valid_q || bus.out_ready);
    assign bus.in_ready = !areset && enable && !clear && (!s1_valid_q || adv);
    assign accept    = bus.in_valid && bus.in_ready;
    assign xfer      = adv && s1_valid_q && !clear;
    assign handshake = s2_valid_q && bus.out_ready;

    assign bus.result    = result_q;
    assign bus.out_valid = s2_valid_q;
    assign count         = count_q;
    assign ready         = !s1_valid_q && !s2_valid_q;

    always_comb begin
        result_d = '0;
        for (int i = 0; i < NUM; i++) begin
            sum[i]   = {1'b0, s1_lane_q[i]} + {1'b0, s1_omega_q};
            diff[i]  = $signed({1'b0, s1_lane_q[i]}) - $signed({1'b0, acc_q[i]});
            acc_d[i] = acc_q[i];
            y[i]     = s1_lane_q[i];
            case (s1_mode_q)
                2'd0: y[i] = s1_lane_q[i];
                2'd1: y[i] = sum[i][W] ? '1 : sum[i][W-1:0];
                2'd2: y[i] = (s1_lane_q[i] >= s1_eps_q) ? s1_lane_q[i] : '0;
                default: begin
                    // Floor-shifted step toward x; the sum always lands back in 0..2**W-1.
                    acc_d[i] = W'($unsigned($signed({1'b0, acc_q[i]}) + (diff[i] >>> SHIFT)));
                    y[i]     = acc_d[i];
                end
            endcase
            result_d[(NUM-1-i)*W +: W] = y[i];
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            count_q    <= '0;
            s1_mode_q  <= '0;
            s1_omega_q <= '0;
            s1_eps_q   <= '0;
            for (int i = 0; i < NUM; i++) begin
                acc_q[i]     <= '0;
                s1_lane_q[i] <= '0;
            end
        end else if (clear) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < NUM; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            if (handshake) begin
                count_q <= count_q + 16'd1;
            end
            if (xfer) begin
                s2_valid_q <= 1'b1;
                result_q   <= result_d;
                for (int i = 0; i < NUM; i++) begin
                    acc_q[i] <= acc_d[i];
                end
            end else if (handshake) begin
                s2_valid_q <= 1'b0;
            end
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_mode_q  <= mode;
                s1_omega_q <= omega;
                s1_eps_q   <= epsilon;
                for (int i = 0; i < NUM; i++) begin
                    s1_lane_q[i] <= bus.flow[i*W +: W];
                end
            end else if (xfer) begin
                s1_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cap_stream.sv
// tb/tb_cap_stream.sv - scoreboard and directed-vector bench for cap_stream
module tb_cap_stream;
    localparam int DEN = 4;

    logic        clk;
    logic        areset;
    logic [1:0]  mode;
    logic [7:0]  omega;
    logic [7:0]  epsilon;
    logic        clear;
    logic        enable;
    logic [15:0] count;
    logic        ready;

    cap_stream_if #(.DW(32)) bus ();

    cap_stream #(.SIZE(3), .NUM(4), .SHIFT(2)) dut (
        .clk     (clk),
        .areset  (areset),
        .mode    (mode),
        .omega   (omega),
        .epsilon (epsilon),
        .clear   (clear),
        .enable  (enable),
        .count   (count),
        .ready   (ready),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: words queued at acceptance, results computed from the lane rules.
    int          m_acc [4];
    logic [31:0] m_q [$];
    logic [15:0] m_count;
    logic        sb_on = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_res;
    logic [31:0] exp_w;

    function automatic logic [31:0] model_word(input logic [1:0] md, input logic [31:0] f,
                                               input logic [7:0] om, input logic [7:0] ep);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            int x;
            int yv;
            int d;
            int q;
            x = int'(f[i*8 +: 8]);
            yv = x;
            case (md)
                2'd0: yv = x;
                2'd1: yv = (x + int'(om) > 255) ? 255 : x + int'(om);
                2'd2: yv = (x >= int'(ep)) ? x : 0;
                default: begin
                    d = x - m_acc[i];
                    q = (d >= 0) ? d / DEN : -((-d + DEN - 1) / DEN);
                    m_acc[i] = m_acc[i] + q;
                    yv = m_acc[i];
                end
            endcase
            r[(3-i)*8 +: 8] = yv[7:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (sb_on) begin
            total++;
            if (count !== m_count) begin
                bad++;
                $display("FAIL sb_count: got %0d expected %0d", count, m_count);
            end
            total++;
            if (ready !== (m_q.size() == 0)) begin
                bad++;
                $display("FAIL sb_ready: got %b expected %b", ready, (m_q.size() == 0));
            end
            if (prev_hold) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.result !== prev_res) begin
                    bad++;
                    $display("FAIL sb_hold: got v=%b r=%h expected v=1 r=%h",
                             bus.out_valid, bus.result, prev_res);
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready && !areset && !clear;
            prev_res  = bus.result;
            if (areset || clear) begin
                m_q.delete();
                for (int i = 0; i < 4; i++) m_acc[i] = 0;
                m_count = '0;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    total++;
                    if (m_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_extra: got %h expected no word", bus.result);
                    end else begin
                        exp_w = m_q.pop_front();
                        if (bus.result !== exp_w) begin
                            bad++;
                            $display("FAIL sb_result: got %h expected %h", bus.result, exp_w);
                        end
                    end
                    m_count = m_count + 16'd1;
                end
                if (bus.in_valid && bus.in_ready)
                    m_q.push_back(model_word(mode, bus.flow, omega, epsilon));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] md, input logic [31:0] f,
                        input logic [7:0] om, input logic [7:0] ep);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.flow = f;
        mode = md;
        omega = om;
        epsilon = ep;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_check(input string name, input logic [1:0] md, input logic [31:0] f,
                              input logic [7:0] om, input logic [7:0] ep, input logic [31:0] exp);
        send(md, f, om, ep);
        @(negedge clk);
        @(negedge clk);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk(name, bus.result, exp);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'(n), 32'd0);
    endtask

    logic [31:0] words [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        areset = 1'b1;
        clear = 1'b0;
        enable = 1'b1;
        mode = 2'd0;
        omega = '0;
        epsilon = '0;
        bus.flow = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        m_count = '0;
        for (int i = 0; i < 4; i++) m_acc[i] = 0;

        @(posedge clk);
        #1;
        sb_on = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Pass-through latency and single-cycle valid.
        send(2'd0, 32'h04030201, 8'h00, 8'h00);
        @(negedge clk);
        chk("lat_early", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("mode0", bus.result, 32'h01020304);
        @(negedge clk);
        chk("lat_one_cycle", 32'(bus.out_valid), 32'd0);
        chk("count_one", 32'(count), 32'd1);

        // Back-pressured stream of six words.
        for (int j = 0; j < 6; j++) words[j] = 32'h11111111 * (j + 1);
        acc_n = 0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        mode = 2'd0;
        bus.flow = words[0];
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (cyc == 4) begin
                chk("bp_accepts", 32'(acc_n), 32'd2);
                chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            end
            if (bus.in_valid && bus.in_ready) acc_n++;
            @(posedge clk);
            #1;
            if (cyc == 4) bus.out_ready = 1'b1;
            if (acc_n < 6) bus.flow = words[acc_n];
            else bus.in_valid = 1'b0;
            if (acc_n == 6 && ready) break;
        end
        wait_idle();
        chk("bp_count", 32'(count), 32'd7);

        send_check("mode1", 2'd1, 32'h20050F00, 8'hF0, 8'h00, 32'hF0FFF5FF);
        send_check("mode2", 2'd2, 32'h0F10FF00, 8'h00, 8'h10, 32'h00FF1000);
        send_check("iir1", 2'd3, 32'h40404040, 8'h00, 8'h00, 32'h10101010);
        send_check("iir2", 2'd3, 32'h40404040, 8'h00, 8'h00, 32'h1C1C1C1C);
        send_check("iir3", 2'd3, 32'h40404040, 8'h00, 8'h00, 32'h25252525);
        send_check("mode0_mid", 2'd0, 32'hDEADBEEF, 8'h00, 8'h00, 32'hEFBEADDE);
        send_check("iir4", 2'd3, 32'h40404040, 8'h00, 8'h00, 32'h2B2B2B2B);
        send_check("iir_down", 2'd3, 32'h00000000, 8'h00, 8'h00, 32'h20202020);
        send(2'd3, 32'h00FF4010, 8'h00, 8'h00);
        send(2'd1, 32'h80FF0001, 8'h7F, 8'h00);
        wait_idle();

        // Disabled pipeline still completes the pending output handshake.
        bus.out_ready = 1'b0;
        send(2'd0, 32'hAABBCCDD, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("en_hold_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        enable = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.flow = 32'h12345678;
        @(negedge clk);
        chk("en_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("en_drained", 32'(bus.out_valid), 32'd0);
        chk("en_no_accept", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        enable = 1'b1;

        // Clear then reset while data is in flight.
        bus.out_ready = 1'b0;
        send(2'd0, 32'h55AA55AA, 8'h00, 8'h00);
        send(2'd0, 32'h01010101, 8'h00, 8'h00);
        @(negedge clk);
        chk("clr_pre_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_ready", 32'(ready), 32'd1);
        send(2'd0, 32'h77777777, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("ar_pre_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        areset = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_ready", 32'(ready), 32'd1);
        send_check("iir_after_reset", 2'd3, 32'h40404040, 8'h00, 8'h00, 32'h10101010);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
